sdc_arbiter: RTL and testbench

- Shares the single sector-read channel of the sd card interface (sdc_rd/sdc_sector/sdc_busy/sdc_done plus byte stream) between NUM_REQ requesters, typically floppy drives DF0..DF3.
- Round-robin scheduling with one outstanding sector transfer at a time.
- Routes the returned 512-byte stream only to the granted requester and signals completion per requester.
- Sits between the floppy controller instances inside minimig and the top-level sdc_* ports of nanomig.

---
 rtl/sdc_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sdc_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_arbiter.sv
// Round-robin arbiter sharing the sd-card sector-read channel between NUM_REQ requesters; grant 1 cycle after request, bytes 1 cycle late.
// No backpressure: host bytes are forwarded unconditionally to the owner. Optional watchdog: define SDC_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module sdc_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 28_000_000
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_rd,
  input  logic [32*NUM_REQ-1:0]  req_sector,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [NUM_REQ-1:0]     req_strobe,
  output logic [8:0]             req_addr,
  output logic [7:0]             req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     sdc_rd,
  output logic [31:0]            sdc_sector,
  input  logic                   sdc_busy,
  input  logic                   sdc_done,
  input  logic                   sdc_byte_in_strobe,
  input  logic [8:0]             sdc_byte_in_addr,
  input  logic [7:0]             sdc_byte_in_data
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sdc_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t              state_q;
  logic [RW-1:0]       rr_q;
  logic [RW-1:0]       gidx_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  sdc_rd_q;
  logic [31:0]         sdc_sector_q;
  logic [NUM_REQ-1:0]  req_done_q;
  logic [NUM_REQ-1:0]  req_strobe_q;
  logic [8:0]          req_addr_q;
  logic [7:0]          req_data_q;

  logic                active;
  logic                complete;
  logic                expire;
  logic                pick_vld;
  logic [RW-1:0]       pick_idx;
  logic [RW-1:0]       cand;

  assign active   = (state_q != S_IDLE);
  assign complete = active && sdc_done;

  // Scan downward so the candidate nearest rr+1 is the last (winning) assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = RW'((int'(rr_q) + k) % NUM_REQ);
      if (req_rd[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_q         <= RW'(NUM_REQ - 1);
      gidx_q       <= '0;
      grant_q      <= '0;
      sdc_rd_q     <= '0;
      sdc_sector_q <= '0;
      req_done_q   <= '0;
      req_strobe_q <= '0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
    end else begin
      req_done_q   <= '0;
      req_strobe_q <= '0;
      // A byte arriving alongside sdc_done is still delivered, aligned with req_done.
      if (active && sdc_byte_in_strobe) begin
        req_strobe_q <= grant_q;
        req_addr_q   <= sdc_byte_in_addr;
        req_data_q   <= sdc_byte_in_data;
      end

      if (complete) begin
        req_done_q <= grant_q;
        grant_q    <= '0;
        sdc_rd_q   <= '0;
        rr_q       <= gidx_q;
        state_q    <= S_IDLE;
      end else if (expire) begin
        grant_q    <= '0;
        sdc_rd_q   <= '0;
        rr_q       <= gidx_q;
        state_q    <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (pick_vld) begin
              grant_q      <= ONE << pick_idx;
              sdc_rd_q     <= ONE << pick_idx;
              sdc_sector_q <= req_sector[32*pick_idx +: 32];
              gidx_q       <= pick_idx;
              state_q      <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (sdc_busy) begin
              sdc_rd_q <= '0;
              state_q  <= S_BUSY;
            end
          end
          S_BUSY: begin
            state_q <= S_BUSY;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SDC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0]      wd_q;
  logic [CW-1:0]      wd_d;
  logic [NUM_REQ-1:0] req_err_q;

  assign wd_d   = wd_q + 1'b1;
  assign expire = active && (wd_d == CW'(TIMEOUT_CYCLES));

  // Completion takes priority over expiry in the same cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wd_q      <= '0;
      req_err_q <= '0;
    end else begin
      req_err_q <= (expire && !complete) ? grant_q : '0;
      if (!active || complete || expire) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_d;
      end
    end
  end

  assign req_err = req_err_q;
`else
  assign expire  = 1'b0;
  assign req_err = '0;
`endif

  assign req_done   = req_done_q;
  assign req_strobe = req_strobe_q;
  assign req_addr   = req_addr_q;
  assign req_data   = req_data_q;
  assign grant      = grant_q;
  assign sdc_rd     = sdc_rd_q;
  assign sdc_sector = sdc_sector_q;

endmodule

// File: tb/tb_sdc_arbiter.sv
// Self-checking bench for sdc_arbiter: randomized host traffic against a round-robin reference model.
`timescale 1ns/1ps
module tb_sdc_arbiter;
  localparam int N  = 4;
  localparam int TO = 100;

  logic           clk_sys = 1'b0;
  logic           reset;
  logic [N-1:0]   req_rd;
  logic [32*N-1:0] req_sector;
  logic [N-1:0]   req_done, req_err, req_strobe, grant, sdc_rd;
  logic [8:0]     req_addr;
  logic [7:0]     req_data;
  logic [31:0]    sdc_sector;
  logic           sdc_busy, sdc_done, sdc_byte_in_strobe;
  logic [8:0]     sdc_byte_in_addr;
  logic [7:0]     sdc_byte_in_data;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int last_g   = N - 1;

  sdc_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys(clk_sys), .reset(reset), .req_rd(req_rd), .req_sector(req_sector),
    .req_done(req_done), .req_err(req_err), .req_strobe(req_strobe),
    .req_addr(req_addr), .req_data(req_data), .grant(grant), .sdc_rd(sdc_rd),
    .sdc_sector(sdc_sector), .sdc_busy(sdc_busy), .sdc_done(sdc_done),
    .sdc_byte_in_strobe(sdc_byte_in_strobe), .sdc_byte_in_addr(sdc_byte_in_addr),
    .sdc_byte_in_data(sdc_byte_in_data)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference: next owner is the first pending requester after the last served one, modulo N.
  function automatic int pick(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task tick;
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  // Plays the host side of one transfer; tallies byte-path deviations from the expected owner g.
  task automatic host_xfer(input int g, input int nbytes, input bit with_busy,
                           output int byte_errs, output logic [N-1:0] done_seen,
                           output logic [N-1:0] rd_after);
    logic [8:0]   a;
    logic [7:0]   d;
    logic [N-1:0] exp_stb;
    byte_errs = 0;
    exp_stb   = N'(1) << g;
    rd_after  = sdc_rd;
    if (with_busy) begin
      sdc_busy = 1'b1;
      tick;
      rd_after = sdc_rd;
      if (req_strobe !== '0 || req_done !== '0) byte_errs++;
    end
    for (int i = 0; i < nbytes; i++) begin
      repeat ($urandom_range(0, 2)) begin
        tick;
        if (req_strobe !== '0 || req_done !== '0) byte_errs++;
      end
      a = 9'(i);
      d = 8'($urandom);
      sdc_byte_in_strobe = 1'b1;
      sdc_byte_in_addr   = a;
      sdc_byte_in_data   = d;
      sdc_done           = (i == nbytes - 1);
      tick;
      sdc_byte_in_strobe = 1'b0;
      sdc_done           = 1'b0;
      if (req_strobe !== exp_stb || req_addr !== a || req_data !== d) byte_errs++;
      if (i != nbytes - 1 && req_done !== '0) byte_errs++;
    end
    done_seen = req_done;
    sdc_busy  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_rd = '0; req_sector = '0;
    sdc_busy = 0; sdc_done = 0; sdc_byte_in_strobe = 0;
    sdc_byte_in_addr = '0; sdc_byte_in_data = '0;
    tick; tick;
    vec_cnt++;
    if ({grant, sdc_rd, req_done, req_err, req_strobe} !== '0 || sdc_sector !== '0 ||
        req_addr !== '0 || req_data !== '0) begin
      $display("FAIL reset_outputs: got grant=%b rd=%b done=%b err=%b stb=%b sec=%h want all zero",
               grant, sdc_rd, req_done, req_err, req_strobe, sdc_sector);
      miss_cnt++;
    end
    reset  = 1'b0;
    last_g = N - 1;
    tick;
    vec_cnt++;
    if (grant !== '0) begin
      $display("FAIL idle_after_reset: got grant=%b want 0000", grant); miss_cnt++;
    end
  endtask

  task automatic test_single;
    int be; logic [N-1:0] dn, rd;
    req_sector[31:0] = 32'h0000_0010;
    req_rd = 4'b0001;
    tick;
    vec_cnt++;
    if (grant !== 4'b0001 || sdc_rd !== 4'b0001 || sdc_sector !== 32'h10) begin
      $display("FAIL single_grant: got grant=%b rd=%b sec=%h want 0001 0001 00000010", grant, sdc_rd, sdc_sector);
      miss_cnt++;
    end
    host_xfer(0, 512, 1'b1, be, dn, rd);
    req_rd = '0;
    vec_cnt++;
    if (rd !== '0) begin $display("FAIL single_rd_drop: got %b want 0000", rd); miss_cnt++; end
    vec_cnt++;
    if (be !== 0) begin $display("FAIL single_bytes: got %0d bad bytes want 0", be); miss_cnt++; end
    vec_cnt++;
    if (dn !== 4'b0001 || grant !== '0) begin
      $display("FAIL single_done: got done=%b grant=%b want 0001 0000", dn, grant); miss_cnt++;
    end
    last_g = 0;
    tick;
    vec_cnt++;
    if (req_done !== '0 || grant !== '0) begin
      $display("FAIL single_done_pulse: got done=%b grant=%b want 0000 0000", req_done, grant); miss_cnt++;
    end
  endtask

  task automatic test_round_robin;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int g, be; logic [N-1:0] dn, rd, pend; logic [31:0] exp_sec;
    reset = 1'b1; tick; reset = 1'b0; last_g = N - 1;
    for (int i = 0; i < N; i++) req_sector[32*i +: 32] = $urandom;
    req_rd = '1;
    for (int t = 0; t < 5; t++) begin
      tick;
      vec_cnt++;
      if (grant !== (N'(1) << exp_order[t]) || sdc_sector !== req_sector[32*exp_order[t] +: 32]) begin
        $display("FAIL rr_order[%0d]: got grant=%b sec=%h want owner %0d", t, grant, sdc_sector, exp_order[t]);
        miss_cnt++;
      end
      host_xfer(exp_order[t], $urandom_range(1, 4), 1'($urandom), be, dn, rd);
      vec_cnt++;
      if (be !== 0 || dn !== (N'(1) << exp_order[t]) || sdc_rd !== '0) begin
        $display("FAIL rr_done[%0d]: got bad=%0d done=%b rd=%b want 0 owner %0d rd 0000", t, be, dn, sdc_rd, exp_order[t]);
        miss_cnt++;
      end
      last_g = exp_order[t];
    end
    for (int t = 0; t < 12; t++) begin
      pend   = N'($urandom_range(1, (1 << N) - 1));
      req_rd = pend;
      tick;
      g = pick(pend, last_g);
      exp_sec = req_sector[32*g +: 32];
      vec_cnt++;
      if (grant !== (N'(1) << g) || sdc_sector !== exp_sec) begin
        $display("FAIL rand_grant[%0d]: got grant=%b sec=%h want owner %0d sec %h", t, grant, sdc_sector, g, exp_sec);
        miss_cnt++;
      end
      for (int i = 0; i < N; i++) req_sector[32*i +: 32] = $urandom;
      tick;
      vec_cnt++;
      if (sdc_sector !== exp_sec || sdc_rd !== (N'(1) << g)) begin
        $display("FAIL rand_latch[%0d]: got sec=%h rd=%b want %h owner %0d", t, sdc_sector, sdc_rd, exp_sec, g);
        miss_cnt++;
      end
      host_xfer(g, $urandom_range(1, 6), 1'($urandom), be, dn, rd);
      vec_cnt++;
      if (be !== 0 || dn !== (N'(1) << g)) begin
        $display("FAIL rand_done[%0d]: got bad=%0d done=%b want 0 owner %0d", t, be, dn, g);
        miss_cnt++;
      end
      last_g = g;
    end
    req_rd = '0;
    tick;
  endtask

  task automatic test_drop;
    int be; logic [N-1:0] dn, rd;
    req_rd = 4'b0100;
    tick;
    vec_cnt++;
    if (grant !== 4'b0100) begin $display("FAIL drop_grant: got %b want 0100", grant); miss_cnt++; end
    sdc_busy = 1'b1;
    tick;
    req_rd = '0;
    host_xfer(2, 16, 1'b0, be, dn, rd);
    vec_cnt++;
    if (be !== 0 || dn !== 4'b0100) begin
      $display("FAIL drop_done: got bad=%0d done=%b want 0 0100", be, dn); miss_cnt++;
    end
    last_g = 2;
    tick;
  endtask

  task automatic test_idle_strobe;
    for (int t = 0; t < 20; t++) begin
      sdc_byte_in_strobe = 1'($urandom);
      sdc_byte_in_addr   = 9'($urandom);
      sdc_byte_in_data   = 8'($urandom);
      sdc_done           = 1'($urandom);
      tick;
      vec_cnt++;
      if (req_strobe !== '0 || req_done !== '0 || grant !== '0) begin
        $display("FAIL idle_strobe[%0d]: got stb=%b done=%b grant=%b want all 0000", t, req_strobe, req_done, grant);
        miss_cnt++;
      end
    end
    sdc_byte_in_strobe = 1'b0;
    sdc_done = 1'b0;
  endtask

  task automatic test_reset_mid;
    int be; logic [N-1:0] dn, rd; logic [31:0] s2;
    req_sector[63:32] = $urandom;
    req_rd = 4'b0010;
    tick;
    vec_cnt++;
    if (grant !== 4'b0010) begin $display("FAIL rst_mid_grant: got %b want 0010", grant); miss_cnt++; end
    sdc_busy = 1'b1;
    tick;
    sdc_byte_in_strobe = 1'b1; sdc_byte_in_addr = 9'd5; sdc_byte_in_data = 8'hA5;
    tick;
    #2 reset = 1'b1;
    #1;
    vec_cnt++;
    if ({grant, sdc_rd, req_strobe, req_done, req_err} !== '0 || sdc_sector !== '0) begin
      $display("FAIL rst_mid_clear: got grant=%b rd=%b stb=%b done=%b sec=%h want all zero",
               grant, sdc_rd, req_strobe, req_done, sdc_sector);
      miss_cnt++;
    end
    sdc_byte_in_strobe = 1'b0; sdc_busy = 1'b0; req_rd = '0;
    @(negedge clk_sys);
    reset = 1'b0; last_g = N - 1;
    sdc_done = 1'b1;
    tick;
    sdc_done = 1'b0;
    tick;
    vec_cnt++;
    if (req_done !== '0 || grant !== '0) begin
      $display("FAIL rst_mid_late_done: got done=%b grant=%b want 0000 0000", req_done, grant); miss_cnt++;
    end
    s2 = $urandom;
    req_sector[63:32] = s2;
    req_rd = 4'b0010;
    tick;
    vec_cnt++;
    if (grant !== 4'b0010 || sdc_sector !== s2) begin
      $display("FAIL rst_mid_regrant: got grant=%b sec=%h want 0010 %h", grant, sdc_sector, s2); miss_cnt++;
    end
    host_xfer(1, 3, 1'b1, be, dn, rd);
    req_rd = '0;
    vec_cnt++;
    if (be !== 0 || dn !== 4'b0010) begin
      $display("FAIL rst_mid_done: got bad=%0d done=%b want 0 0010", be, dn); miss_cnt++;
    end
    last_g = 1;
    tick;
  endtask

  task automatic test_timeout;
    int be; logic [N-1:0] dn, rd;
`ifdef SDC_ARB_TIMEOUT_EN
    int g, n;
    req_rd = 4'b0011;
    tick;
    g = pick(4'b0011, last_g);
    vec_cnt++;
    if (grant !== (N'(1) << g)) begin $display("FAIL to_grant: got %b want owner %0d", grant, g); miss_cnt++; end
    n = 0;
    while (req_err === '0 && n < 2 * TO) begin tick; n++; end
    vec_cnt++;
    if (n !== TO || req_err !== (N'(1) << g) || sdc_rd !== '0 || req_done !== '0) begin
      $display("FAIL to_expire: got cycles=%0d err=%b rd=%b done=%b want %0d owner %0d", n, req_err, sdc_rd, req_done, TO, g);
      miss_cnt++;
    end
    last_g = g;
    g = pick(4'b0011, last_g);
    tick;
    vec_cnt++;
    if (grant !== (N'(1) << g) || req_err !== '0) begin
      $display("FAIL to_next: got grant=%b err=%b want owner %0d err 0000", grant, req_err, g); miss_cnt++;
    end
    host_xfer(g, 1, 1'b0, be, dn, rd);
    req_rd = '0;
    vec_cnt++;
    if (be !== 0 || dn !== (N'(1) << g)) begin
      $display("FAIL to_recover: got bad=%0d done=%b want 0 owner %0d", be, dn, g); miss_cnt++;
    end
    last_g = g;
`else
    int errs;
    req_rd = 4'b0001;
    tick;
    errs = 0;
    repeat (10000) begin
      tick;
      if (req_err !== '0) errs++;
    end
    vec_cnt++;
    if (errs !== 0 || sdc_rd !== 4'b0001) begin
      $display("FAIL no_timeout: got err cycles=%0d rd=%b want 0 0001", errs, sdc_rd); miss_cnt++;
    end
    host_xfer(pick(4'b0001, last_g), 1, 1'b0, be, dn, rd);
    req_rd = '0;
    vec_cnt++;
    if (be !== 0 || dn !== 4'b0001) begin
      $display("FAIL no_timeout_done: got bad=%0d done=%b want 0 0001", be, dn); miss_cnt++;
    end
    last_g = 0;
`endif
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_drop;
    test_idle_strobe;
    test_reset_mid;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
